tile_renderer: RTL
==================

// Module: tile_renderer
// PURPOSE
//   Read-side client of the tile-map and glyph SRAMs. It is the VGA beam-driven reader for the
//   80x60 tile map and the 8x8 glyph store, which the game logic writes.
//   Per pixel: converts beam position to a map address, then a glyph-bit address, then a 3-bit RGB pixel.
//   Sits between the VGA timing generator and the video DAC pins.
//   Delays sync by the pipeline depth so that pixels and sync stay aligned.
// PARAMETERS
//   MAP_AW      13   tile-map address width (80*60 = 4800 cells)
//   TILE_W      3    tile-map data width (tile code)
//   GLYPH_AW    9    glyph RAM address width (6 glyphs * 64 bits = 384)
//   SYNC_IDLE   1    idle level of hsync/vsync (1 = negative-going pulses)
//   BLINK_BIT   4    frame-counter bit that gates the food glyph (blink period 2^(BLINK_BIT+1) frames)
// PORTS
//   i_clk          in   1        pixel clock
//   i_rstn         in   1        synchronous reset, active low
//   i_hcount       in   10       beam x, 0..639 active
//   i_vcount       in   10       beam y, 0..479 active
//   i_active       in   1        beam inside visible area
//   i_hsync        in   1        raw hsync from timing generator
//   i_vsync        in   1        raw vsync from timing generator
//   o_map_addr     out  MAP_AW   tile-map read address (map RAM: i_write tied 0)
//   i_map_data     in   TILE_W   tile-map read data, valid 1 clk after o_map_addr
//   o_glyph_addr   out  GLYPH_AW glyph RAM read address
//   i_glyph_data   in   1        glyph bit, valid 1 clk after o_glyph_addr
//   o_rgb          out  3        pixel colour {r,g,b}
//   o_hsync        out  1        hsync delayed 2 clk
//   o_vsync        out  1        vsync delayed 2 clk
// BEHAVIOUR
//   Both RAMs are registered-read (1 clk latency). The pipeline is 3 stages, so latency is 2 clk from beam inputs to o_rgb/o_*sync.
//   S0 (comb+reg): tx=i_hcount[9:3], ty=i_vcount[8:3].
//     o_map_addr = ty*80+tx, computed as (ty<<6)+(ty<<4)+tx. Max 4799; no wrap.
//     Register col=i_hcount[2:0], row=i_vcount[2:0], active, hsync, vsync into S1.
//   S1: tile=i_map_data. Valid codes: 0 empty, 1 head, 2 body, 3 reserved, 4 wall, 5 food.
//     o_glyph_addr = {tile,row,col} = tile*64+row*8+col for tile<=5.
//     For tile>5: o_glyph_addr=0 and the pixel is forced off.
//     Register tile, active, hsync, vsync into S2.
//   S2: bit=i_glyph_data. o_rgb = (active_d2 & bit & visible) ? COLOUR(tile_d2) : 3'b000.
//     COLOUR: 1->3'b010, 2->3'b011, 3->3'b111, 4->3'b001, 5->3'b100, 0->3'b000.
//     visible=0 for tile 5 when frame_cnt[BLINK_BIT]=1, and for tile>5; otherwise 1.
//   o_map_addr / o_glyph_addr are registered outputs. During blanking they are still driven from
//     i_hcount/i_vcount (harmless reads); the pixel is masked by the delayed active.
//   frame_cnt: 8-bit, +1 on the first clk where raw i_vsync != SYNC_IDLE and the previous sample == SYNC_IDLE.
//     Wraps 255->0.
//   Reset (i_rstn=0 at posedge): all pipeline regs 0; o_rgb=0; o_map_addr=0; o_glyph_addr=0;
//     o_hsync=o_vsync=SYNC_IDLE; frame_cnt=0; vsync edge-detect register=SYNC_IDLE.
//     Reset mid-line drops in-flight pixels. The first valid pixel appears 2 clk after release.
//   Out-of-range beam (hcount>=640 or vcount>=480 with i_active=1) is a caller error.
//     The address is then not clamped, and the output is undefined but must not hang.
//   No handshakes: the block is free-running, one pixel per clk, with no stall.
// TESTING
//   1 Map cell (ty=25,tx=20)=4, glyph 4 all ones, beam at (160,200) active -> o_map_addr=2020 at +1 clk,
//     o_glyph_addr=256 at +2, o_rgb=3'b001 at +2 clk vs beam inputs.
//   2 Glyph 5 row 3 = 8'b00000001 (col0 only), cell (22,5)=5, beam x=40..47, y=179 ->
//     o_rgb=3'b100 only for x=40, 0 elsewhere; o_glyph_addr=5*64+3*8+col.
//   3 Drive 16 vsync pulses (SYNC_IDLE=1) -> frame_cnt=16, food pixels all 0 for frames 16..31;
//     wall pixels unaffected.
//   4 i_hsync/i_vsync arbitrary pattern -> o_hsync/o_vsync equal input delayed exactly 2 clk;
//     i_active=0 -> o_rgb=0 regardless of map contents.
//   5 Assert i_rstn=0 for 1 clk mid-line -> next clk o_rgb=0, o_hsync=o_vsync=1, frame_cnt=0;
//     correct pixels resume 2 clk after release.
//   6 Map cell code 6 or 7 -> o_glyph_addr=0, o_rgb=0 for all 64 pixels of that tile.

Source files
------------

// File: rtl/tile_renderer.sv
// Beam-driven tile renderer: maps beam position to a tile-map read, then a glyph-bit read, then a 3-bit pixel.
// The registered address outputs act as the RAM address registers, so pixels and sync emerge 2 clk after the beam.
module tile_renderer #(
   parameter int       MAP_AW    = 13,
   parameter int       TILE_W    = 3,
   parameter int       GLYPH_AW  = 9,
   parameter logic     SYNC_IDLE = 1'b1,
   parameter int       BLINK_BIT = 4
) (
   input  logic                i_clk,
   input  logic                i_rstn,
   input  logic [9:0]          i_hcount,
   input  logic [9:0]          i_vcount,
   input  logic                i_active,
   input  logic                i_hsync,
   input  logic                i_vsync,
   output logic [MAP_AW-1:0]   o_map_addr,
   input  logic [TILE_W-1:0]   i_map_data,
   output logic [GLYPH_AW-1:0] o_glyph_addr,
   input  logic                i_glyph_data,
   output logic [2:0]          o_rgb,
   output logic                o_hsync,
   output logic                o_vsync
);

   localparam logic [TILE_W-1:0] TILE_FOOD = TILE_W'(5);

   logic [MAP_AW-1:0]   tx_ext;
   logic [MAP_AW-1:0]   ty_ext;
   logic [MAP_AW-1:0]   map_addr_next;
   logic [GLYPH_AW-1:0] glyph_addr_next;

   logic [MAP_AW-1:0]   map_addr_reg;
   logic [2:0]          col_d1_reg;
   logic [2:0]          row_d1_reg;
   logic                active_d1_reg;
   logic                hsync_d1_reg;
   logic                vsync_d1_reg;

   logic [GLYPH_AW-1:0] glyph_addr_reg;
   logic [TILE_W-1:0]   tile_d2_reg;
   logic                active_d2_reg;
   logic                hsync_d2_reg;
   logic                vsync_d2_reg;

   logic [7:0]          frame_cnt_reg;
   logic                vsync_prev_reg;

   logic [2:0]          colour;
   logic                visible;

   // ty*80 + tx as shifts; the largest legal cell (59,79) gives 4799.
   assign tx_ext        = MAP_AW'(i_hcount[9:3]);
   assign ty_ext        = MAP_AW'(i_vcount[8:3]);
   assign map_addr_next = (ty_ext << 6) + (ty_ext << 4) + tx_ext;

   assign glyph_addr_next = (i_map_data <= TILE_FOOD) ?
                            GLYPH_AW'({i_map_data, row_d1_reg, col_d1_reg}) : '0;

   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         map_addr_reg   <= '0;
         col_d1_reg     <= '0;
         row_d1_reg     <= '0;
         active_d1_reg  <= 1'b0;
         hsync_d1_reg   <= SYNC_IDLE;
         vsync_d1_reg   <= SYNC_IDLE;
         glyph_addr_reg <= '0;
         tile_d2_reg    <= '0;
         active_d2_reg  <= 1'b0;
         hsync_d2_reg   <= SYNC_IDLE;
         vsync_d2_reg   <= SYNC_IDLE;
      end else begin
         map_addr_reg   <= map_addr_next;
         col_d1_reg     <= i_hcount[2:0];
         row_d1_reg     <= i_vcount[2:0];
         active_d1_reg  <= i_active;
         hsync_d1_reg   <= i_hsync;
         vsync_d1_reg   <= i_vsync;
         glyph_addr_reg <= glyph_addr_next;
         tile_d2_reg    <= i_map_data;
         active_d2_reg  <= active_d1_reg;
         hsync_d2_reg   <= hsync_d1_reg;
         vsync_d2_reg   <= vsync_d1_reg;
      end
   end

   // Frame counter advances on the leading edge of each raw vsync pulse.
   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         frame_cnt_reg  <= '0;
         vsync_prev_reg <= SYNC_IDLE;
      end else begin
         vsync_prev_reg <= i_vsync;
         if ((i_vsync != SYNC_IDLE) && (vsync_prev_reg == SYNC_IDLE)) begin
            frame_cnt_reg <= frame_cnt_reg + 8'd1;
         end
      end
   end

   always_comb begin
      colour = 3'b000;
      case (tile_d2_reg)
         TILE_W'(1): colour = 3'b010;
         TILE_W'(2): colour = 3'b011;
         TILE_W'(3): colour = 3'b111;
         TILE_W'(4): colour = 3'b001;
         TILE_W'(5): colour = 3'b100;
         default:    colour = 3'b000;
      endcase
   end

   always_comb begin
      visible = 1'b1;
      if (tile_d2_reg > TILE_FOOD) begin
         visible = 1'b0;
      end else if ((tile_d2_reg == TILE_FOOD) && frame_cnt_reg[BLINK_BIT]) begin
         visible = 1'b0;
      end
   end

   assign o_rgb        = (active_d2_reg && i_glyph_data && visible) ? colour : 3'b000;
   assign o_map_addr   = map_addr_reg;
   assign o_glyph_addr = glyph_addr_reg;
   assign o_hsync      = hsync_d2_reg;
   assign o_vsync      = vsync_d2_reg;

endmodule
